// File: rtl/pgm_pkg.sv
// Shared state encoding, header tags and widths for the packet-generator replay scheduler.
package pgm_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_READ = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } sched_state_e;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_MID  = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  localparam int PKT_W       = 134;
  localparam int RAM_W       = 144;
  localparam int MIN_PKT_LEN = 2;

  function automatic logic [1:0] hdr_tag(input logic first, input logic last);
    return first ? HDR_HEAD : (last ? HDR_TAIL : HDR_MID);
  endfunction

endpackage

// File: rtl/pgm_sched_gap.sv
// Loadable down-counter with zero flag; times the idle cycles between replayed packets.
module pgm_sched_gap #(
  parameter int GAP_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [GAP_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [GAP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pgm_sched.sv
// Replays the template packet held in the pgm RAM onto the pkt bus toward goe.
// Optional macro PGM_SEQ_STAMP_EN stamps the packet index into line 1 bits [31:0].
//   state | meaning
//   IDLE  | waiting for an accepted start
//   WAIT  | packet boundary; issue line 0 once downstream is not almost-full
//   READ  | reading lines 1..len-1 back-to-back
//   GAP   | inter-packet idle cycles
//   DONE  | drain the read pipeline, pulse finish, back to IDLE
module pgm_sched #(
  parameter int ADDR_W = 7,
  parameter int RAM_W  = 144,
  parameter int GAP_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  input  logic                      cfg_stop,
  input  logic [7:0]                cfg_pkt_len,
  input  logic [CNT_W-1:0]          cfg_repeat,
  input  logic [GAP_W-1:0]          cfg_gap,
  output logic                      rd2ram_rd,
  output logic [ADDR_W-1:0]         rd2ram_addr,
  input  logic [RAM_W-1:0]          ram2rd_rdata,
  output logic [pgm_pkg::PKT_W-1:0] out_sched_data,
  output logic                      out_sched_data_wr,
  output logic                      out_sched_valid,
  output logic                      out_sched_valid_wr,
  input  logic                      in_sched_alf,
  output logic                      pgm_sent_start_flag,
  output logic                      pgm_sent_finish_flag,
  output logic                      sched_busy,
  output logic                      sched_err,
  output logic [CNT_W-1:0]          sched_sent_cnt
);
  import pgm_pkg::*;

  localparam int MAX_LINE = (1 << ADDR_W) - 1;

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr, len_m1_q, len_m1_sat;
  logic [7:0]        len_m1_raw;
  logic [CNT_W-1:0]  rep_q, issued_q, sent_q;
  logic [GAP_W-1:0]  gap_q;
  logic              stop_pend_q, err_q, start_flag_q;
  logic              rvld_q, rfirst_q, rlast_q;
  logic [PKT_W-1:0]  out_data_q, out_word;
  logic              out_wr_q, out_tail_q;
  logic              rd, last_rd, gap_load, gap_dec, gap_zero, finish;
  logic              accept, reject, pkts_done;
  logic              unused_rdata_hi;

  assign unused_rdata_hi = ^ram2rd_rdata[RAM_W-1:PKT_W];

  // Stop wins over a simultaneous start; a start outside IDLE is ignored.
  assign accept = (state_q == S_IDLE) && cfg_start && !cfg_stop && (cfg_pkt_len >= 8'(MIN_PKT_LEN));
  assign reject = (state_q == S_IDLE) && cfg_start && !cfg_stop && (cfg_pkt_len <  8'(MIN_PKT_LEN));

  assign len_m1_raw = cfg_pkt_len - 8'd1;
  assign len_m1_sat = (len_m1_raw > 8'(MAX_LINE)) ? ADDR_W'(MAX_LINE) : len_m1_raw[ADDR_W-1:0];

  assign pkts_done = (rep_q != '0) && ((issued_q + CNT_W'(1)) == rep_q);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd       = 1'b0;
    rd_addr  = addr_q;
    last_rd  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cfg_stop) begin
          state_d = S_DONE;
        end else if (!in_sched_alf) begin
          rd      = 1'b1;
          rd_addr = '0;
          addr_d  = ADDR_W'(1);
          state_d = S_READ;
        end
      end
      S_READ: begin
        rd = 1'b1;
        if (addr_q == len_m1_q) begin
          last_rd = 1'b1;
          addr_d  = '0;
          if (pkts_done || stop_pend_q || cfg_stop) begin
            state_d = S_DONE;
          end else if (gap_q != '0) begin
            gap_load = 1'b1;
            state_d  = S_GAP;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_GAP: begin
        if (cfg_stop) begin
          state_d = S_DONE;
        end else if (gap_zero) begin
          state_d = S_WAIT;
        end else begin
          gap_dec = 1'b1;
        end
      end
      S_DONE: begin
        // Hold until the tail word has left the output register.
        if (!rvld_q && !out_wr_q) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  pgm_sched_gap #(.GAP_W(GAP_W)) u_gap (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (gap_load),
    .load_val_i (gap_q - GAP_W'(1)),
    .dec_i      (gap_dec),
    .zero_o     (gap_zero)
  );

`ifdef PGM_SEQ_STAMP_EN
  logic        rline1_q;
  logic [31:0] stamp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rline1_q <= 1'b0;
      stamp_q  <= '0;
    end else begin
      rline1_q <= rd && (rd_addr == ADDR_W'(1));
      stamp_q  <= 32'(issued_q);
    end
  end
`endif

  always_comb begin
    out_word = ram2rd_rdata[PKT_W-1:0];
    out_word[PKT_W-1 -: 2] = hdr_tag(rfirst_q, rlast_q);
`ifdef PGM_SEQ_STAMP_EN
    if (rline1_q) out_word[31:0] = stamp_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_m1_q     <= '0;
      rep_q        <= '0;
      gap_q        <= '0;
      issued_q     <= '0;
      sent_q       <= '0;
      stop_pend_q  <= 1'b0;
      err_q        <= 1'b0;
      start_flag_q <= 1'b0;
      rvld_q       <= 1'b0;
      rfirst_q     <= 1'b0;
      rlast_q      <= 1'b0;
      out_data_q   <= '0;
      out_wr_q     <= 1'b0;
      out_tail_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (accept) begin
        len_m1_q <= len_m1_sat;
        rep_q    <= cfg_repeat;
        gap_q    <= cfg_gap;
      end
      if (accept)       issued_q <= '0;
      else if (last_rd) issued_q <= issued_q + CNT_W'(1);
      if (accept)                  sent_q <= '0;
      else if (rvld_q && rlast_q)  sent_q <= sent_q + CNT_W'(1);
      if (accept || finish)                         stop_pend_q <= 1'b0;
      else if (cfg_stop && (state_q != S_IDLE))     stop_pend_q <= 1'b1;
      if (accept)      err_q <= 1'b0;
      else if (reject) err_q <= 1'b1;
      if (accept)      start_flag_q <= 1'b1;
      else if (finish) start_flag_q <= 1'b0;
      rvld_q   <= rd;
      rfirst_q <= rd && (rd_addr == '0);
      rlast_q  <= rd && (rd_addr == len_m1_q);
      if (rvld_q) out_data_q <= out_word;
      out_wr_q   <= rvld_q;
      out_tail_q <= rvld_q && rlast_q;
    end
  end

  assign rd2ram_rd            = rd;
  assign rd2ram_addr          = rd_addr;
  assign out_sched_data       = out_data_q;
  assign out_sched_data_wr    = out_wr_q;
  assign out_sched_valid      = out_tail_q;
  assign out_sched_valid_wr   = out_tail_q;
  assign pgm_sent_start_flag  = start_flag_q;
  assign pgm_sent_finish_flag = finish;
  assign sched_busy           = (state_q != S_IDLE);
  assign sched_err            = err_q;
  assign sched_sent_cnt       = sent_q;

endmodule

// File: tb/tb_pgm_sched.sv
// Self-checking bench for pgm_sched: config table, corner sequences and randomized alf runs.
module tb_pgm_sched;
  localparam int ADDR_W = 7;
  localparam int RAM_W  = 144;
  localparam int GAP_W  = 16;
  localparam int CNT_W  = 32;
  localparam int PKT_W  = 134;
`ifdef PGM_SEQ_STAMP_EN
  localparam bit STAMP_EN = 1'b1;
`else
  localparam bit STAMP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, cfg_start, cfg_stop, in_sched_alf;
  logic [7:0]        cfg_pkt_len;
  logic [CNT_W-1:0]  cfg_repeat;
  logic [GAP_W-1:0]  cfg_gap;
  logic              rd2ram_rd;
  logic [ADDR_W-1:0] rd2ram_addr;
  logic [RAM_W-1:0]  ram2rd_rdata = '0;
  logic [PKT_W-1:0]  out_sched_data;
  logic              out_sched_data_wr, out_sched_valid, out_sched_valid_wr;
  logic              pgm_sent_start_flag, pgm_sent_finish_flag, sched_busy, sched_err;
  logic [CNT_W-1:0]  sched_sent_cnt;

  pgm_sched #(.ADDR_W(ADDR_W), .RAM_W(RAM_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cfg_start            (cfg_start),
    .cfg_stop             (cfg_stop),
    .cfg_pkt_len          (cfg_pkt_len),
    .cfg_repeat           (cfg_repeat),
    .cfg_gap              (cfg_gap),
    .rd2ram_rd            (rd2ram_rd),
    .rd2ram_addr          (rd2ram_addr),
    .ram2rd_rdata         (ram2rd_rdata),
    .out_sched_data       (out_sched_data),
    .out_sched_data_wr    (out_sched_data_wr),
    .out_sched_valid      (out_sched_valid),
    .out_sched_valid_wr   (out_sched_valid_wr),
    .in_sched_alf         (in_sched_alf),
    .pgm_sent_start_flag  (pgm_sent_start_flag),
    .pgm_sent_finish_flag (pgm_sent_finish_flag),
    .sched_busy           (sched_busy),
    .sched_err            (sched_err),
    .sched_sent_cnt       (sched_sent_cnt)
  );

  // RAM model, one cycle read latency.
  logic [RAM_W-1:0] ram [128];
  always @(posedge clk) if (rd2ram_rd) ram2rd_rdata <= ram[rd2ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [PKT_W-1:0] q_word[$];
  int               q_cyc[$];
  bit               q_tail[$];
  int               n_fin, n_rd;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_sched_data_wr) begin
        q_word.push_back(out_sched_data);
        q_cyc.push_back(cyc);
        q_tail.push_back(out_sched_valid_wr && out_sched_valid);
      end
      if (pgm_sent_finish_flag) n_fin++;
      if (rd2ram_rd) n_rd++;
    end
  end

  bit rnd_alf = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rnd_alf) in_sched_alf = ($urandom_range(0, 3) == 0);
  end

  int total = 0, bad = 0;
  int st_cyc;

  task automatic chk(input string nm, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference word: RAM line with the header tag forced, optional packet-index stamp on line 1.
  function automatic logic [PKT_W-1:0] exp_word(input int k, input int len, input int pkt);
    logic [RAM_W-1:0] line;
    logic [PKT_W-1:0] w;
    line = ram[k];
    w = line[PKT_W-1:0];
    w[133:132] = (k == 0) ? 2'b01 : ((k == len - 1) ? 2'b10 : 2'b11);
    if (STAMP_EN && (k == 1)) w[31:0] = 32'(pkt);
    return w;
  endfunction

  task automatic check_stream(input string tag, input int len, input int npkt, input int gap, input bit exact);
    int n;
    n = len * npkt;
    chki({tag, "_nwords"}, q_word.size(), n);
    for (int i = 0; i < q_word.size() && i < n; i++) begin
      int k;
      int p;
      k = i % len;
      p = i / len;
      chk({tag, "_word"}, q_word[i], exp_word(k, len, p));
      chki({tag, "_tailflag"}, int'(q_tail[i]), int'(k == len - 1));
      if (k > 0) chki({tag, "_b2b"}, q_cyc[i] - q_cyc[i-1], 1);
      else if (p > 0) begin
        if (exact) chki({tag, "_gap"}, q_cyc[i] - q_cyc[i-1] - 1, gap);
        else       chki({tag, "_gapmin"}, int'((q_cyc[i] - q_cyc[i-1] - 1) >= gap), 1);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input bit with_stop);
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_stop = with_stop; st_cyc = cyc;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_stop = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1; cfg_stop = 1'b1;
    @(posedge clk); #1; cfg_stop = 1'b0;
  endtask

  task automatic wait_finish(input string nm, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (pgm_sent_finish_flag) seen = 1'b1;
    end
    chki({nm, "_finish_seen"}, int'(seen), 1);
  endtask

  task automatic clear_mon();
    q_word.delete(); q_cyc.delete(); q_tail.delete();
    n_fin = 0; n_rd = 0;
  endtask

  task automatic set_cfg(input int len, input int rep, input int gap);
    cfg_pkt_len = 8'(len); cfg_repeat = CNT_W'(rep); cfg_gap = GAP_W'(gap);
  endtask

  task automatic check_all_zero(input string tag);
    chki({tag, "_rd"},       int'(rd2ram_rd), 0);
    chki({tag, "_data_wr"},  int'(out_sched_data_wr), 0);
    chki({tag, "_valid"},    int'(out_sched_valid), 0);
    chki({tag, "_valid_wr"}, int'(out_sched_valid_wr), 0);
    chki({tag, "_startfl"},  int'(pgm_sent_start_flag), 0);
    chki({tag, "_finfl"},    int'(pgm_sent_finish_flag), 0);
    chki({tag, "_busy"},     int'(sched_busy), 0);
    chki({tag, "_err"},      int'(sched_err), 0);
    chki({tag, "_sent"},     int'(sched_sent_cnt), 0);
    chk ({tag, "_data"},     out_sched_data, '0);
  endtask

  typedef struct {
    int len;
    int rep;
    int gap;
    bit exp_err;
    int exp_words;
    int exp_sent;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; in_sched_alf = 1'b0;
    set_cfg(0, 0, 0);
    for (int i = 0; i < 128; i++) ram[i] = {16'($urandom), $urandom, $urandom, $urandom, $urandom};

    vecs[0] = '{len: 1,   rep: 1, gap: 0, exp_err: 1'b1, exp_words: 0,   exp_sent: 0};
    vecs[1] = '{len: 2,   rep: 1, gap: 0, exp_err: 1'b0, exp_words: 2,   exp_sent: 1};
    vecs[2] = '{len: 4,   rep: 2, gap: 3, exp_err: 1'b0, exp_words: 8,   exp_sent: 2};
    vecs[3] = '{len: 3,   rep: 3, gap: 1, exp_err: 1'b0, exp_words: 9,   exp_sent: 3};
    vecs[4] = '{len: 128, rep: 1, gap: 5, exp_err: 1'b0, exp_words: 128, exp_sent: 1};
    vecs[5] = '{len: 5,   rep: 4, gap: 0, exp_err: 1'b0, exp_words: 20,  exp_sent: 4};
    vecs[6] = '{len: 0,   rep: 2, gap: 0, exp_err: 1'b1, exp_words: 0,   exp_sent: 4};

    step(3);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    for (int v = 0; v < NV; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      clear_mon();
      set_cfg(vecs[v].len, vecs[v].rep, vecs[v].gap);
      pulse_start(1'b0);
      if (vecs[v].exp_err) step(6);
      else begin
        wait_finish(nm, (vecs[v].len + vecs[v].gap + 4) * vecs[v].rep + 20);
        step(3);
      end
      @(negedge clk);
      chki({nm, "_err"},     int'(sched_err), int'(vecs[v].exp_err));
      chki({nm, "_sent"},    int'(sched_sent_cnt), vecs[v].exp_sent);
      chki({nm, "_words"},   q_word.size(), vecs[v].exp_words);
      chki({nm, "_nfin"},    n_fin, vecs[v].exp_err ? 0 : 1);
      chki({nm, "_busy"},    int'(sched_busy), 0);
      chki({nm, "_startfl"}, int'(pgm_sent_start_flag), 0);
      if (vecs[v].exp_err) chki({nm, "_nrd"}, n_rd, 0);
      else begin
        check_stream(nm, vecs[v].len, vecs[v].rep, vecs[v].gap, 1'b1);
        if (q_cyc.size() > 0) chki({nm, "_latency"}, q_cyc[0] - st_cyc, 3);
      end
    end

    // Start and stop together in IDLE: nothing happens, earlier err stays.
    clear_mon();
    set_cfg(4, 1, 0);
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chki("startstop_busy", int'(sched_busy), 0);
    end
    chki("startstop_nrd", n_rd, 0);
    chki("startstop_err", int'(sched_err), 1);
    chki("startstop_sent", int'(sched_sent_cnt), 4);

    // alf held through start, then dropped, then raised mid-packet.
    clear_mon();
    in_sched_alf = 1'b1;
    set_cfg(3, 1, 0);
    pulse_start(1'b0);
    step(3);
    @(negedge clk);
    chki("alf_startfl", int'(pgm_sent_start_flag), 1);
    chki("alf_busy", int'(sched_busy), 1);
    chki("alf_nrd", n_rd, 0);
    chki("alf_err", int'(sched_err), 0);
    begin
      int drop_cyc;
      @(posedge clk); #1;
      in_sched_alf = 1'b0; drop_cyc = cyc;
      @(posedge clk); #1;
      in_sched_alf = 1'b1;
      wait_finish("alf", 30);
      step(2);
      if (q_cyc.size() > 0) chki("alf_head_time", q_cyc[0] - drop_cyc, 2);
    end
    check_stream("alf", 3, 1, 0, 1'b1);

    // Stop while parked in WAIT: no packet is read.
    clear_mon();
    set_cfg(2, 1, 0);
    pulse_start(1'b0);
    step(2);
    pulse_stop();
    wait_finish("stopwait", 20);
    step(2);
    chki("stopwait_nrd", n_rd, 0);
    chki("stopwait_sent", int'(sched_sent_cnt), 0);
    in_sched_alf = 1'b0;

    // Endless replay, stop in the middle of packet 3.
    clear_mon();
    set_cfg(4, 0, 0);
    pulse_start(1'b0);
    for (int i = 0; i < 100 && q_word.size() < 8; i++) @(negedge clk);
    chki("stopmid_reached", int'(q_word.size() >= 8), 1);
    pulse_stop();
    wait_finish("stopmid", 40);
    step(3);
    @(negedge clk);
    chki("stopmid_sent", int'(sched_sent_cnt), 3);
    chki("stopmid_nfin", n_fin, 1);
    check_stream("stopmid", 4, 3, 0, 1'b1);

    // Randomized runs with alf toggling every cycle.
    for (int r = 0; r < 6; r++) begin
      int len, rep, gap;
      string nm;
      nm = $sformatf("rnd%0d", r);
      len = $urandom_range(2, 24);
      rep = $urandom_range(1, 4);
      gap = $urandom_range(0, 4);
      clear_mon();
      set_cfg(len, rep, gap);
      rnd_alf = 1'b1;
      pulse_start(1'b0);
      wait_finish(nm, (len + gap + 4) * rep * 8 + 100);
      rnd_alf = 1'b0;
      step(1);
      in_sched_alf = 1'b0;
      step(2);
      @(negedge clk);
      chki({nm, "_sent"}, int'(sched_sent_cnt), rep);
      chki({nm, "_nfin"}, n_fin, 1);
      check_stream(nm, len, rep, gap, 1'b0);
    end

    // Synchronous reset while reading.
    clear_mon();
    set_cfg(16, 1, 0);
    pulse_start(1'b0);
    step(3);
    @(negedge clk);
    chki("rstmid_inread", int'(rd2ram_rd), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rstmid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/pgm_sched.md
Name: pgm_sched

Overview:
- Replay scheduler for the packet-generator RAM (144 bits x 128 lines).
- Once the packet-writer has stored a template packet, pgm_sched reads it line by line from the RAM read port and emits it on the 134-bit pkt bus toward goe.
- Replays a configured number of times with a configurable inter-packet gap.
- Drives the sent-start/sent-finish flags that the rest of the pgm sequencing uses.

Parameters:
- ADDR_W, 7, RAM address width (128 lines).
- RAM_W, 144, RAM data width; low 134 bits carry the pkt bus word.
- GAP_W, 16, width of the inter-packet gap counter.
- CNT_W, 32, width of the repeat and sent counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_start  in  1  one-cycle pulse: begin replay
- cfg_stop  in  1  one-cycle pulse: stop after the current packet
- cfg_pkt_len  in  8  template length in lines, legal range 2..128
- cfg_repeat  in  CNT_W  packets to send; 0 = run until stop
- cfg_gap  in  GAP_W  idle cycles between packets
- rd2ram_rd  out  1  RAM read enable
- rd2ram_addr  out  ADDR_W  RAM read address
- ram2rd_rdata  in  RAM_W  RAM read data, 1-cycle latency
- out_sched_data  out  134  pkt word
- out_sched_data_wr  out  1  pkt word strobe
- out_sched_valid  out  1  pkt valid (always 1 when strobed)
- out_sched_valid_wr  out  1  strobe with the tail word
- in_sched_alf  in  1  downstream almost-full
- pgm_sent_start_flag  out  1  high while replay is active
- pgm_sent_finish_flag  out  1  one-cycle pulse when replay completes
- sched_busy  out  1  state != IDLE
- sched_err  out  1  sticky: start was rejected because cfg_pkt_len < 2; cleared by the next accepted start
- sched_sent_cnt  out  CNT_W  packets fully emitted since the last accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-packet abandons the packet with no tail emitted; downstream discards truncated packets.
- States: IDLE, WAIT, READ, GAP, DONE.
- IDLE:
  - cfg_start with len >= 2 latches len, repeat and gap, then goes to WAIT.
  - cfg_start with len < 2 sets sched_err and stays in IDLE.
  - cfg_start and cfg_stop in the same cycle: stop wins, start is ignored.
  - cfg_start while not in IDLE is ignored.
- WAIT: if in_sched_alf = 0, go to READ with address 0. alf is sampled only at packet boundaries; once a packet starts it is never paused.
- READ:
  - rd2ram_rd = 1 each cycle, address increments 0..len-1.
  - Each returned word is registered onto out_sched_data with out_sched_data_wr = 1.
  - Latency: start pulse at cycle 0, first rd at cycle 1, first out_sched_data_wr at cycle 3. Words are back-to-back.
- Header tag override on bits [133:132]: first line 2'b01, last line 2'b10, all others 2'b11. Bits [131:0] pass through from RAM.
- Tail word: out_sched_valid_wr = 1 and out_sched_valid = 1; sched_sent_cnt increments.
- After the last read is issued:
  - Done when repeat != 0 and issued packets == repeat, or when a stop is pending; go to DONE after the tail is emitted.
  - Otherwise go to GAP if gap > 0, else to WAIT.
- GAP: counts gap cycles after the tail word, then goes to WAIT. gap = 0 gives back-to-back packets, subject only to alf.
- Stop: cfg_stop in any non-IDLE state sets stop_pending.
  - In WAIT or GAP: go to DONE immediately; no new packet starts.
  - In READ: finish the current packet, then DONE.
- DONE: pulse pgm_sent_finish_flag for 1 cycle, clear pgm_sent_start_flag, return to IDLE.
- pgm_sent_start_flag is set on the cycle of entry to WAIT from IDLE.
- Counters wrap modulo 2^CNT_W. The issued-packet compare uses the full CNT_W width.

Optional Feature:
- Macro: PGM_SEQ_STAMP_EN.
- Defined: bits [31:0] of line 1 (the second metadata word) of every emitted packet are replaced by the 32-bit issued-packet index, starting at 0 for the first packet after start.
- Undefined: line 1 passes through from RAM unmodified.
- Header tag override applies in both builds.

Decomposition:
- Package pgm_pkg:
  - state encoding;
  - header tag constants HDR_HEAD = 2'b01, HDR_MID = 2'b11, HDR_TAIL = 2'b10;
  - PKT_W = 134, RAM_W = 144, MIN_PKT_LEN = 2.
- One natural sub-module: pgm_sched_gap, a loadable GAP_W down-counter with a zero flag, reused for the gap wait.

Test Plan:
- len = 4, repeat = 2, gap = 3, alf = 0, start pulse:
  - 8 words, tags 01/11/11/10 twice;
  - exactly 3 idle cycles between the two tails/heads;
  - finish pulse once; sched_sent_cnt = 2;
  - first data_wr 3 cycles after start.
- len = 1, start: sched_err = 1, no rd, state stays IDLE. A subsequent start with len = 2 clears err and emits 2 words.
- repeat = 0, gap = 0, stop pulsed mid-packet 3:
  - packet 3 completes with its tail, no packet 4;
  - finish pulse; sched_sent_cnt = 3.
- alf = 1 held through start: sent_start_flag = 1, no rd. alf dropped: packet starts next cycle. alf raised mid-packet: packet continues uninterrupted.
- Start and stop in the same cycle in IDLE: no activity, busy stays 0. Reset asserted mid-READ: all outputs 0 next cycle.
- PGM_SEQ_STAMP_EN build, repeat = 3: line 1 bits [31:0] = 0, 1, 2 across the packets; other bits match RAM.
